// File: rtl/vram_bus_responder.sv
// VRAM bus slave: arbitrates NUM_PORTS word-read masters onto one VRAM read port.
// Define VRAM_BUS_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module vram_bus_responder #(
    parameter int NUM_PORTS   = 2,
    parameter int RAM_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [18*NUM_PORTS-1:0]  m_addr,
    input  logic [NUM_PORTS-1:0]     m_strobe,
    output logic [31:0]              m_rddata,
    output logic [NUM_PORTS-1:0]     m_ack,
    output logic [15:0]              ram_addr,
    output logic                     ram_rden,
    input  logic [31:0]              ram_rddata,
    output logic                     busy
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [IDX_W-1:0]       grant_r, grant_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [15:0]            ram_addr_r, ram_addr_s;
    logic                   ram_rden_r, ram_rden_s;
    logic [NUM_PORTS-1:0]   m_ack_r, m_ack_s;
    logic [31:0]            m_rddata_r, m_rddata_s;
    logic                   busy_r;
    logic [IDX_W-1:0]       sel_s;
    logic                   req_any_s;
    logic                   grant_en_s;
    logic [15:0]            port_word_s [NUM_PORTS];
    logic [2*NUM_PORTS-1:0] addr_lsb_unused_s;

    // Byte address bits [1:0] carry no meaning for word reads.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign port_word_s[gi]              = m_addr[18*gi+2 +: 16];
        assign addr_lsb_unused_s[2*gi +: 2] = m_addr[18*gi +: 2];
    end

    assign req_any_s  = |m_strobe;
    assign grant_en_s = (state_r == ST_IDLE) && req_any_s;

`ifdef VRAM_BUS_FIXED_PRIO_EN
    // Lowest requesting index wins; the descending scan leaves it last.
    always_comb begin
        sel_s = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            sel_s = m_strobe[i] ? IDX_W'(i) : sel_s;
        end
    end
`else
    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] idx_s;

    // First requester after the last grant wins; scan runs farthest-first so the nearest overwrites.
    always_comb begin
        sel_s = '0;
        idx_s = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx_s = IDX_W'((int'(ptr_r) + k) % NUM_PORTS);
            sel_s = m_strobe[idx_s] ? idx_s : sel_s;
        end
    end

    // Round-robin pointer remembers the most recent grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= IDX_W'(NUM_PORTS - 1);
        end else if (grant_en_s) begin
            ptr_r <= sel_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`endif

    // Next-state and datapath: grant in IDLE, wait out RAM latency in READ, pulse ack in ACK.
    always_comb begin
        state_s    = state_r;
        grant_s    = grant_r;
        cnt_s      = cnt_r;
        ram_addr_s = ram_addr_r;
        ram_rden_s = 1'b0;
        m_ack_s    = '0;
        m_rddata_s = m_rddata_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_en_s) begin
                    state_s    = ST_READ;
                    grant_s    = sel_s;
                    cnt_s      = CNT_W'(RAM_LATENCY);
                    ram_addr_s = port_word_s[sel_s];
                    ram_rden_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    m_rddata_s       = ram_rddata;
                    m_ack_s[grant_r] = 1'b1;
                    state_s          = ST_ACK;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            grant_r    <= '0;
            cnt_r      <= '0;
            ram_addr_r <= 16'h0000;
            ram_rden_r <= 1'b0;
            m_ack_r    <= '0;
            m_rddata_r <= 32'h0000_0000;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            grant_r    <= grant_s;
            cnt_r      <= cnt_s;
            ram_addr_r <= ram_addr_s;
            ram_rden_r <= ram_rden_s;
            m_ack_r    <= m_ack_s;
            m_rddata_r <= m_rddata_s;
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    assign ram_addr = ram_addr_r;
    assign ram_rden = ram_rden_r;
    assign m_ack    = m_ack_r;
    assign m_rddata = m_rddata_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_vram_bus_responder.sv
// Bench for vram_bus_responder: transaction-level model checked every cycle, plus directed cases.
// Expectations follow VRAM_BUS_FIXED_PRIO_EN when it is defined for the build.
module tb_vram_bus_responder;

    localparam int NP   = 2;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [18*NP-1:0]  m_addr;
    logic [NP-1:0]     m_strobe;
    logic [31:0]       m_rddata;
    logic [NP-1:0]     m_ack;
    logic [15:0]       ram_addr;
    logic              ram_rden;
    logic [31:0]       ram_rddata;
    logic              busy;

    logic [18*NP-1:0]  m3_addr;
    logic [NP-1:0]     m3_strobe;
    logic [31:0]       m3_rddata;
    logic [NP-1:0]     m3_ack;
    logic [15:0]       ram3_addr;
    logic              ram3_rden;
    logic [31:0]       ram3_rddata;
    logic              busy3;

    logic [31:0] ram_q;
    logic [31:0] r3_s0, r3_s1, r3_s2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    vram_bus_responder #(.NUM_PORTS(NP), .RAM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .m_addr(m_addr), .m_strobe(m_strobe),
        .m_rddata(m_rddata), .m_ack(m_ack), .ram_addr(ram_addr),
        .ram_rden(ram_rden), .ram_rddata(ram_rddata), .busy(busy)
    );

    vram_bus_responder #(.NUM_PORTS(NP), .RAM_LATENCY(LAT3)) dut3 (
        .clk(clk), .rst(rst), .m_addr(m3_addr), .m_strobe(m3_strobe),
        .m_rddata(m3_rddata), .m_ack(m3_ack), .ram_addr(ram3_addr),
        .ram_rden(ram3_rden), .ram_rddata(ram3_rddata), .busy(busy3)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (a == 16'h1234) return 32'hDEADBEEF;
        return {a ^ 16'hA5C3, ~a};
    endfunction

    // VRAM models: data appears LAT cycles after the read-enable cycle.
    always_ff @(posedge clk) begin
        if (ram_rden) ram_q <= mem_word(ram_addr);
    end
    assign ram_rddata = ram_q;

    always_ff @(posedge clk) begin
        if (ram3_rden) r3_s0 <= mem_word(ram3_addr);
        r3_s1 <= r3_s0;
        r3_s2 <= r3_s1;
    end
    assign ram3_rddata = r3_s2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [NP-1:0] s, input int last);
`ifdef VRAM_BUS_FIXED_PRIO_EN
        for (int i = 0; i < NP; i++) if (s[i]) return i;
`else
        for (int k = 1; k <= NP; k++) if (s[(last + k) % NP]) return (last + k) % NP;
`endif
        return -1;
    endfunction

    // Transaction-level model: a grant in cycle g gives rden in g+1, busy g+1..g+2+LAT, ack in g+2+LAT.
    initial begin : model
        bit          have_txn;
        int          g, p, rr_last, nowc, cur, w;
        logic [15:0] a;
        logic [31:0] d;
        logic [NP-1:0] e_ack;
        logic [31:0] e_data;
        logic [15:0] e_addr;
        logic        e_rden, e_busy;
        have_txn = 1'b0; g = 0; p = 0; rr_last = NP - 1; a = 16'h0; d = 32'h0;
        e_ack = '0; e_data = 32'h0; e_addr = 16'h0; e_rden = 1'b0; e_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_txn = 1'b0; rr_last = NP - 1;
                e_ack = '0; e_data = 32'h0; e_addr = 16'h0; e_rden = 1'b0; e_busy = 1'b0;
            end
            chk("m_ack", 32'(m_ack), 32'(e_ack));
            chk("m_rddata", m_rddata, e_data);
            chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            chk("ram_rden", 32'(ram_rden), 32'(e_rden));
            chk("busy", 32'(busy), 32'(e_busy));
            if (!rst) begin
                nowc = cyc;
                if ((!have_txn || nowc >= g + 3 + LAT) && (m_strobe != '0)) begin
                    w = pick(m_strobe, rr_last);
                    p = w; rr_last = w; g = nowc; have_txn = 1'b1;
                    a = m_addr[18*w+2 +: 16];
                    d = mem_word(a);
                end
                cur    = nowc + 1;
                e_busy = have_txn && (cur >= g + 1) && (cur <= g + 2 + LAT);
                e_rden = have_txn && (cur == g + 1);
                if (have_txn) e_addr = a;
                e_ack = '0;
                if (have_txn && cur == g + 2 + LAT) begin
                    e_ack[p] = 1'b1;
                    e_data   = d;
                end
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One request from an idle bus; ack must land exactly in cycle 3.
    task automatic single_read(input int port, input logic [17:0] addr, input logic [NP-1:0] exp_ack);
        step();
        m_addr[18*port +: 18] = addr;
        m_strobe[port] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            m_strobe = m_strobe & ~m_ack;
            #3;
            if (c == 1) begin
                chk("rd_ram_addr", 32'(ram_addr), 32'h0000_1234);
                chk("rd_ram_rden", 32'(ram_rden), 32'h1);
            end
            chk("rd_ack_timing", 32'(m_ack), (c == 3) ? 32'(exp_ack) : 32'h0);
            if (c == 3) chk("rd_data", m_rddata, 32'hDEADBEEF);
        end
    endtask

    initial begin : stim
        int ack_port [4];
        int ack_cyc  [4];
        int exp_order [4];
        int nack, rden_cnt, rden_cyc, ack3_cyc, r;
        bit seen_p1, cont;
        logic [31:0] data3;
        rst = 1'b1;
        m_strobe = '0; m_addr = '0; m3_strobe = '0; m3_addr = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_ack", 32'(m_ack), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_rddata", m_rddata, 32'h0);
        rst = 1'b0;

        single_read(0, 18'h048D0, 2'b01);
        single_read(1, 18'h048D3, 2'b10);

        // Contention: both ports strobe, each re-strobing right after its ack.
`ifdef VRAM_BUS_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        nack = 0;
        step();
        m_addr = {18'h00020, 18'h00010};
        m_strobe = 2'b11;
        for (int c = 1; c <= 24; c++) begin
            step();
            m_strobe = ~m_ack;
            #3;
            chk("ack_onehot", 32'($countones(m_ack) <= 1), 32'h1);
            if (m_ack != '0 && nack < 4) begin
                ack_port[nack] = (m_ack == 2'b10) ? 1 : 0;
                ack_cyc[nack]  = c;
                nack++;
            end
        end
        chk("contention_acks", 32'(nack), 32'd4);
        for (int k = 0; k < 4 && k < nack; k++) begin
            chk("grant_order", 32'(ack_port[k]), 32'(exp_order[k]));
            if (k > 0) chk("ack_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd4);
        end
        // Port 0 goes idle; port 1 must then be served.
        seen_p1 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            m_strobe = {~m_ack[1] & ~seen_p1, 1'b0};
            if (m_ack[1]) seen_p1 = 1'b1;
        end
        chk("p1_after_p0_idle", 32'(seen_p1), 32'h1);
        m_strobe = '0;
        repeat (6) step();

        // Latency 3 instance: single read, ack five cycles after the strobe.
        rden_cnt = 0; rden_cyc = -1; ack3_cyc = -1; data3 = 32'h0;
        m3_addr[17:0] = 18'h048D0;
        m3_strobe = 2'b01;
        for (int c = 1; c <= 8; c++) begin
            step();
            m3_strobe = m3_strobe & ~m3_ack;
            #3;
            if (ram3_rden) begin rden_cnt++; rden_cyc = c; end
            if (m3_ack != '0 && ack3_cyc < 0) begin ack3_cyc = c; data3 = m3_rddata; end
        end
        chk("lat3_rden_pulses", 32'(rden_cnt), 32'd1);
        chk("lat3_rden_cycle", 32'(rden_cyc), 32'd1);
        chk("lat3_ack_cycle", 32'(ack3_cyc), 32'd5);
        chk("lat3_data", data3, 32'hDEADBEEF);

        // Reset during READ aborts the read with no ack afterwards.
        step();
        m_addr[17:0] = 18'h048D0;
        m_strobe = 2'b01;
        step();
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_rden", 32'(ram_rden), 32'h0);
        chk("midrst_addr", 32'(ram_addr), 32'h0);
        chk("midrst_rddata", m_rddata, 32'h0);
        step();
        rst = 1'b0;
        m_strobe = '0;
        nack = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            #3;
            if (m_ack != '0) nack++;
        end
        chk("no_ack_after_rst", 32'(nack), 32'd0);
        single_read(0, 18'h048D0, 2'b01);

        // Randomized traffic, including withdrawn strobes and addresses changed while held.
        for (int n = 0; n < 3000; n++) begin
            step();
            cont = ((n / 500) % 2) == 1;
            for (int i = 0; i < NP; i++) begin
                if (m_ack[i]) begin
                    m_strobe[i] = 1'b0;
                end else if (m_strobe[i]) begin
                    r = int'($urandom_range(0, 63));
                    if (r == 0) m_strobe[i] = 1'b0;
                    else if (r < 5) m_addr[18*i +: 18] = 18'($urandom);
                end else if (cont || $urandom_range(0, 3) == 0) begin
                    m_strobe[i] = 1'b1;
                    if ($urandom_range(0, 7) == 0) m_addr[18*i +: 18] = 18'h048D0 | 18'($urandom_range(0, 3));
                    else m_addr[18*i +: 18] = 18'($urandom);
                end
            end
        end
        m_strobe = '0;
        repeat (8) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
